uart_cmd_ctrl: RTL and testbench

//  Command sequencer between the UART receiver/transmitter and the register file/ALU.

---
 rtl/uart_cmd_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between UART RX/TX and the register file / ALU.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TMO_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     rx_p_data,
    input  logic                  rx_d_vld,
    input  logic [DATA_W-1:0]     rf_rd_data,
    input  logic                  rf_rd_vld,
    input  logic [2*DATA_W-1:0]   alu_out,
    input  logic                  alu_out_vld,
    input  logic                  tx_busy,
    output logic [ADDR_W-1:0]     rf_addr,
    output logic [DATA_W-1:0]     rf_wr_data,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic                  alu_en,
    output logic [3:0]            alu_fun,
    output logic                  clk_gate_en,
    output logic [DATA_W-1:0]     tx_p_data,
    output logic                  tx_d_vld,
    output logic                  cmd_err
);

    typedef enum logic [3:0] {
        StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StOpA, StOpB,
        StAluFun, StAluWait, StTxLo, StTxHi
    } state_e;

    localparam logic [DATA_W-1:0] CmdWr    = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] CmdRd    = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] CmdAlu   = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] CmdAluNo = DATA_W'(8'hDD);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]     rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]     rf_wr_data_q, rf_wr_data_d;
    logic                  rf_wr_en_q, rf_wr_en_d;
    logic                  rf_rd_en_q, rf_rd_en_d;
    logic [3:0]            alu_fun_q, alu_fun_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  two_byte_q, two_byte_d;
    logic [DATA_W-1:0]     tx_data_q, tx_data_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  tmo_hit;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TMO_CYC + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_counting;

    // Counts only while a command is partially received; any byte restarts it.
    assign tmo_counting = (state_q inside {StWrAddr, StWrData, StRdAddr, StRdWait,
                                           StOpA, StOpB, StAluFun});

    always_comb begin
        tmo_cnt_d = '0;
        tmo_hit   = 1'b0;
        if (tmo_counting && !rx_d_vld) begin
            if (tmo_cnt_q == TmoW'(TMO_CYC - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_fun_d    = alu_fun_q;
        result_d     = result_q;
        two_byte_d   = two_byte_q;
        tx_data_d    = tx_data_q;
        tx_vld_d     = tx_vld_q;
        cmd_err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_d_vld) begin
                    if (rx_p_data == CmdWr) begin
                        state_d = StWrAddr;
                    end else if (rx_p_data == CmdRd) begin
                        state_d = StRdAddr;
                    end else if (rx_p_data == CmdAlu) begin
                        state_d = StOpA;
                    end else if (rx_p_data == CmdAluNo) begin
                        state_d = StAluFun;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            StWrAddr: begin
                if (rx_d_vld) begin
                    wr_addr_d = rx_p_data[ADDR_W-1:0];
                    state_d   = StWrData;
                end
            end
            StWrData: begin
                if (rx_d_vld) begin
                    rf_addr_d    = wr_addr_q;
                    rf_wr_data_d = rx_p_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = StIdle;
                end
            end
            StRdAddr: begin
                if (rx_d_vld) begin
                    rf_addr_d  = rx_p_data[ADDR_W-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = StRdWait;
                end
            end
            StRdWait: begin
                if (rf_rd_vld) begin
                    result_d   = {{DATA_W{1'b0}}, rf_rd_data};
                    two_byte_d = 1'b0;
                    state_d    = StTxLo;
                    // Start the TX request straight away to save a cycle.
                    if (!tx_busy) begin
                        tx_vld_d  = 1'b1;
                        tx_data_d = rf_rd_data;
                    end
                end
            end
            StOpA: begin
                if (rx_d_vld) begin
                    rf_addr_d    = '0;
                    rf_wr_data_d = rx_p_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = StOpB;
                end
            end
            StOpB: begin
                if (rx_d_vld) begin
                    rf_addr_d    = ADDR_W'(1);
                    rf_wr_data_d = rx_p_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = StAluFun;
                end
            end
            StAluFun: begin
                if (rx_d_vld) begin
                    alu_fun_d = rx_p_data[3:0];
                    state_d   = StAluWait;
                end
            end
            StAluWait: begin
                if (alu_out_vld) begin
                    result_d   = alu_out;
                    two_byte_d = 1'b1;
                    state_d    = StTxLo;
                    if (!tx_busy) begin
                        tx_vld_d  = 1'b1;
                        tx_data_d = alu_out[DATA_W-1:0];
                    end
                end
            end
            StTxLo: begin
                if (!tx_vld_q) begin
                    if (!tx_busy) begin
                        tx_vld_d  = 1'b1;
                        tx_data_d = result_q[DATA_W-1:0];
                    end
                end else if (tx_busy) begin
                    tx_vld_d = 1'b0;
                    state_d  = two_byte_q ? StTxHi : StIdle;
                end
            end
            StTxHi: begin
                if (!tx_vld_q) begin
                    if (!tx_busy) begin
                        tx_vld_d  = 1'b1;
                        tx_data_d = result_q[2*DATA_W-1:DATA_W];
                    end
                end else if (tx_busy) begin
                    tx_vld_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (tmo_hit) begin
            state_d   = StIdle;
            tx_vld_d  = 1'b0;
            cmd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_addr_q    <= '0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            alu_fun_q    <= '0;
            result_q     <= '0;
            two_byte_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_vld_q     <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            alu_fun_q    <= alu_fun_d;
            result_q     <= result_d;
            two_byte_q   <= two_byte_d;
            tx_data_q    <= tx_data_d;
            tx_vld_q     <= tx_vld_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign rf_addr     = rf_addr_q;
    assign rf_wr_data  = rf_wr_data_q;
    assign rf_wr_en    = rf_wr_en_q;
    assign rf_rd_en    = rf_rd_en_q;
    assign alu_fun     = alu_fun_q;
    assign alu_en      = (state_q == StAluWait);
    assign clk_gate_en = (state_q == StAluFun) || (state_q == StAluWait);
    assign tx_p_data   = tx_data_q;
    assign tx_d_vld    = tx_vld_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl.
// Timeout scenario runs only when CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_ctrl;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned TMO_CYC = 16;

    logic                clk;
    logic                rst_n;
    logic [DATA_W-1:0]   rx_p_data;
    logic                rx_d_vld;
    logic [DATA_W-1:0]   rf_rd_data;
    logic                rf_rd_vld;
    logic [2*DATA_W-1:0] alu_out;
    logic                alu_out_vld;
    logic                tx_busy;
    logic [ADDR_W-1:0]   rf_addr;
    logic [DATA_W-1:0]   rf_wr_data;
    logic                rf_wr_en;
    logic                rf_rd_en;
    logic                alu_en;
    logic [3:0]          alu_fun;
    logic                clk_gate_en;
    logic [DATA_W-1:0]   tx_p_data;
    logic                tx_d_vld;
    logic                cmd_err;

    int checks;
    int failures;
    int wr_cnt, rd_cnt, alu_cnt, tx_cnt, err_cnt;

    uart_cmd_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_p_data  (rx_p_data),
        .rx_d_vld   (rx_d_vld),
        .rf_rd_data (rf_rd_data),
        .rf_rd_vld  (rf_rd_vld),
        .alu_out    (alu_out),
        .alu_out_vld(alu_out_vld),
        .tx_busy    (tx_busy),
        .rf_addr    (rf_addr),
        .rf_wr_data (rf_wr_data),
        .rf_wr_en   (rf_wr_en),
        .rf_rd_en   (rf_rd_en),
        .alu_en     (alu_en),
        .alu_fun    (alu_fun),
        .clk_gate_en(clk_gate_en),
        .tx_p_data  (tx_p_data),
        .tx_d_vld   (tx_d_vld),
        .cmd_err    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Activity counters; a TX byte counts when request and busy meet at an edge.
    always @(posedge clk) begin
        if (rf_wr_en) wr_cnt++;
        if (rf_rd_en) rd_cnt++;
        if (alu_en) alu_cnt++;
        if (tx_d_vld && tx_busy) tx_cnt++;
        if (cmd_err) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_p_data = b;
        rx_d_vld  = 1'b1;
        tick(1);
        rx_d_vld  = 1'b0;
    endtask

    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; alu_cnt = 0; tx_cnt = 0; err_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_p_data = '0; rx_d_vld = 0; rf_rd_data = '0; rf_rd_vld = 0;
        alu_out = '0; alu_out_vld = 0; tx_busy = 0;
        tick(3);
        checks++;
        if ({rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_en, alu_fun, clk_gate_en,
             tx_p_data, tx_d_vld, cmd_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%h wd=%h we=%b re=%b ae=%b fun=%h cg=%b tx=%h tv=%b err=%b required all 0",
                     rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_en, alu_fun, clk_gate_en,
                     tx_p_data, tx_d_vld, cmd_err);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset_mid_wr();
        send_byte(8'hAA);
        send_byte(8'h03);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        clear_counts();
        send_byte(8'hAA);
        send_byte(8'h05);
        checks++;
        if (rf_wr_en !== 1'b0) begin
            failures++; $display("FAIL wr_early: rf_wr_en got %b required 0", rf_wr_en);
        end
        send_byte(8'h5A);
        checks++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h5, 8'h5A}) begin
            failures++;
            $display("FAIL wr_strobe: got we=%b addr=%h data=%h required we=1 addr=5 data=5a",
                     rf_wr_en, rf_addr, rf_wr_data);
        end
        tick(2);
        checks++;
        if (wr_cnt !== 1 || rf_wr_en !== 1'b0 || rf_addr !== 4'h5) begin
            failures++;
            $display("FAIL wr_single: got count=%0d we=%b addr=%h required count=1 we=0 addr=5",
                     wr_cnt, rf_wr_en, rf_addr);
        end
    endtask

    task automatic test_read();
        clear_counts();
        tx_busy = 1'b0;
        send_byte(8'hBB);
        send_byte(8'h05);
        checks++;
        if ({rf_rd_en, rf_addr, rf_wr_en} !== {1'b1, 4'h5, 1'b0}) begin
            failures++;
            $display("FAIL rd_strobe: got re=%b addr=%h we=%b required re=1 addr=5 we=0",
                     rf_rd_en, rf_addr, rf_wr_en);
        end
        tick(2);
        rf_rd_data = 8'h5A;
        rf_rd_vld  = 1'b1;
        tick(1);
        rf_rd_vld  = 1'b0;
        checks++;
        if ({tx_d_vld, tx_p_data} !== {1'b1, 8'h5A}) begin
            failures++;
            $display("FAIL rd_tx_latency: got vld=%b data=%h required vld=1 data=5a",
                     tx_d_vld, tx_p_data);
        end
        tick(3);
        checks++;
        if ({tx_d_vld, tx_p_data} !== {1'b1, 8'h5A}) begin
            failures++;
            $display("FAIL rd_tx_hold: got vld=%b data=%h required vld=1 data=5a",
                     tx_d_vld, tx_p_data);
        end
        tx_busy = 1'b1;
        tick(1);
        checks++;
        if (tx_d_vld !== 1'b0) begin
            failures++; $display("FAIL rd_tx_drop: tx_d_vld got %b required 0", tx_d_vld);
        end
        tick(2);
        tx_busy = 1'b0;
        tick(3);
        checks++;
        if (tx_d_vld !== 1'b0 || tx_cnt !== 1 || rd_cnt !== 1) begin
            failures++;
            $display("FAIL rd_one_byte: got vld=%b tx=%0d rd=%0d required vld=0 tx=1 rd=1",
                     tx_d_vld, tx_cnt, rd_cnt);
        end
    endtask

    task automatic test_alu();
        clear_counts();
        send_byte(8'hCC);
        send_byte(8'h10);
        checks++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h0, 8'h10}) begin
            failures++;
            $display("FAIL alu_opa: got we=%b addr=%h data=%h required we=1 addr=0 data=10",
                     rf_wr_en, rf_addr, rf_wr_data);
        end
        send_byte(8'h20);
        checks++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h1, 8'h20}) begin
            failures++;
            $display("FAIL alu_opb: got we=%b addr=%h data=%h required we=1 addr=1 data=20",
                     rf_wr_en, rf_addr, rf_wr_data);
        end
        send_byte(8'h00);
        tick(2);
        checks++;
        if ({alu_en, clk_gate_en, alu_fun, rf_wr_en} !== {1'b1, 1'b1, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL alu_en: got en=%b cg=%b fun=%h we=%b required en=1 cg=1 fun=0 we=0",
                     alu_en, clk_gate_en, alu_fun, rf_wr_en);
        end
        alu_out     = 16'h0030;
        alu_out_vld = 1'b1;
        tick(1);
        alu_out_vld = 1'b0;
        checks++;
        if ({alu_en, clk_gate_en, tx_d_vld, tx_p_data} !== {1'b0, 1'b0, 1'b1, 8'h30}) begin
            failures++;
            $display("FAIL alu_tx_lo: got en=%b cg=%b vld=%b data=%h required en=0 cg=0 vld=1 data=30",
                     alu_en, clk_gate_en, tx_d_vld, tx_p_data);
        end
        tx_busy = 1'b1;
        tick(2);
        tx_busy = 1'b0;
        tick(1);
        checks++;
        if ({tx_d_vld, tx_p_data} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL alu_tx_hi: got vld=%b data=%h required vld=1 data=00",
                     tx_d_vld, tx_p_data);
        end
        tx_busy = 1'b1;
        tick(1);
        tx_busy = 1'b0;
        tick(3);
        checks++;
        if (tx_d_vld !== 1'b0 || tx_cnt !== 2 || wr_cnt !== 2) begin
            failures++;
            $display("FAIL alu_done: got vld=%b tx=%0d wr=%0d required vld=0 tx=2 wr=2",
                     tx_d_vld, tx_cnt, wr_cnt);
        end
    endtask

    task automatic test_alu_no_busy();
        clear_counts();
        tx_busy = 1'b1;
        send_byte(8'hDD);
        send_byte(8'h02);
        checks++;
        if ({alu_en, alu_fun} !== {1'b1, 4'h2}) begin
            failures++;
            $display("FAIL aluno_fun: got en=%b fun=%h required en=1 fun=2", alu_en, alu_fun);
        end
        alu_out     = 16'h1234;
        alu_out_vld = 1'b1;
        tick(1);
        alu_out_vld = 1'b0;
        tick(3);
        checks++;
        if (tx_d_vld !== 1'b0 || alu_en !== 1'b0) begin
            failures++;
            $display("FAIL aluno_busy_wait: got vld=%b en=%b required vld=0 en=0", tx_d_vld, alu_en);
        end
        tx_busy = 1'b0;
        tick(1);
        checks++;
        if ({tx_d_vld, tx_p_data} !== {1'b1, 8'h34}) begin
            failures++;
            $display("FAIL aluno_tx_lo: got vld=%b data=%h required vld=1 data=34",
                     tx_d_vld, tx_p_data);
        end
        tx_busy = 1'b1;
        tick(1);
        tx_busy = 1'b0;
        tick(1);
        checks++;
        if ({tx_d_vld, tx_p_data} !== {1'b1, 8'h12}) begin
            failures++;
            $display("FAIL aluno_tx_hi: got vld=%b data=%h required vld=1 data=12",
                     tx_d_vld, tx_p_data);
        end
        tx_busy = 1'b1;
        tick(1);
        tx_busy = 1'b0;
        tick(2);
        checks++;
        if (tx_d_vld !== 1'b0 || tx_cnt !== 2 || wr_cnt !== 0) begin
            failures++;
            $display("FAIL aluno_done: got vld=%b tx=%0d wr=%0d required vld=0 tx=2 wr=0",
                     tx_d_vld, tx_cnt, wr_cnt);
        end
    endtask

    task automatic test_unknown_cmd();
        clear_counts();
        send_byte(8'h55);
        checks++;
        if (cmd_err !== 1'b1) begin
            failures++; $display("FAIL err_pulse: cmd_err got %b required 1", cmd_err);
        end
        tick(1);
        checks++;
        if (cmd_err !== 1'b0) begin
            failures++; $display("FAIL err_one_cycle: cmd_err got %b required 0", cmd_err);
        end
        tick(2);
        checks++;
        if (wr_cnt + rd_cnt + alu_cnt + tx_cnt !== 0 || err_cnt !== 1 || tx_d_vld !== 1'b0) begin
            failures++;
            $display("FAIL err_quiet: got wr=%0d rd=%0d alu=%0d tx=%0d err=%0d required 0 0 0 0 1",
                     wr_cnt, rd_cnt, alu_cnt, tx_cnt, err_cnt);
        end
        send_byte(8'hAA);
        send_byte(8'h07);
        send_byte(8'hC3);
        checks++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h7, 8'hC3}) begin
            failures++;
            $display("FAIL err_recover: got we=%b addr=%h data=%h required we=1 addr=7 data=c3",
                     rf_wr_en, rf_addr, rf_wr_data);
        end
        tick(1);
    endtask

    task automatic test_drop_during_wait();
        clear_counts();
        send_byte(8'hBB);
        send_byte(8'h02);
        tick(1);
        send_byte(8'hAA);
        send_byte(8'h99);
        tick(1);
        rf_rd_data = 8'h77;
        rf_rd_vld  = 1'b1;
        tick(1);
        rf_rd_vld  = 1'b0;
        checks++;
        if ({tx_d_vld, tx_p_data, cmd_err} !== {1'b1, 8'h77, 1'b0} || err_cnt !== 0) begin
            failures++;
            $display("FAIL drop_rdwait: got vld=%b data=%h err=%0d required vld=1 data=77 err=0",
                     tx_d_vld, tx_p_data, err_cnt);
        end
        send_byte(8'h42);
        tx_busy = 1'b1;
        tick(1);
        tx_busy = 1'b0;
        tick(2);
        checks++;
        if (err_cnt !== 0 || wr_cnt !== 0 || rf_addr !== 4'h2 || tx_cnt !== 1) begin
            failures++;
            $display("FAIL drop_quiet: got err=%0d wr=%0d addr=%h tx=%0d required 0 0 2 1",
                     err_cnt, wr_cnt, rf_addr, tx_cnt);
        end
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout();
        clear_counts();
        send_byte(8'hAA);
        send_byte(8'h03);
        tick(TMO_CYC - 1);
        checks++;
        if (cmd_err !== 1'b0) begin
            failures++; $display("FAIL tmo_early: cmd_err got %b required 0", cmd_err);
        end
        tick(1);
        checks++;
        if (cmd_err !== 1'b1) begin
            failures++; $display("FAIL tmo_pulse: cmd_err got %b required 1", cmd_err);
        end
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h5A);
        checks++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h5, 8'h5A} || wr_cnt !== 0) begin
            failures++;
            $display("FAIL tmo_recover: got we=%b addr=%h data=%h prior_wr=%0d required 1 5 5a 0",
                     rf_wr_en, rf_addr, rf_wr_data, wr_cnt);
        end
        tick(1);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        clear_counts();
        test_reset();
        test_reset_mid_wr();
        test_read();
        test_alu();
        test_alu_no_busy();
        test_unknown_cmd();
        test_drop_during_wait();
`ifdef CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
